axicb_resp_router: RTL and testbench
====================================

Name: axicb_resp_router

Overview:
- Return-path companion to the crossbar's per-slave round-robin arbiter.
- The arbiter merges master AR requests toward one slave; this block records which master won each accepted AR.
- It then steers that slave's R-channel bursts back to the correct master, in issue order, one burst at a time.
- One instance sits beside each slave-side arbiter.

Parameters:
- MST_NB, 4, number of masters (2..4); width of grant and per-master valid/ready vectors.
- DATA_W, 32, R data width.
- ID_W, 8, R ID width.
- OSTDG_DEPTH, 4, maximum outstanding read transactions; power of two, ≥2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset, sampled on rising aclk.
- grant  in  MST_NB  one-hot arbiter grant, valid in the AR handshake cycle.
- mst_arvalid  in  1  muxed AR valid from the granted master.
- mst_arready  out  1  AR ready back to the granted master.
- slv_arvalid  out  1  AR valid to the slave.
- slv_arready  in  1  AR ready from the slave.
- slv_rvalid  in  1  R valid from the slave.
- slv_rready  out  1  R ready to the slave.
- slv_rdata  in  DATA_W  R data.
- slv_rresp  in  2  R response.
- slv_rid  in  ID_W  R ID.
- slv_rlast  in  1  last beat of the burst.
- mst_rvalid  out  MST_NB  per-master R valid.
- mst_rready  in  MST_NB  per-master R ready.
- mst_rdata  out  DATA_W  broadcast R data.
- mst_rresp  out  2  broadcast R response.
- mst_rid  out  ID_W  broadcast R ID.
- mst_rlast  out  1  broadcast RLAST.
- ostd_cnt  out  $clog2(OSTDG_DEPTH)+1  outstanding transaction count.
- err  out  1  sticky protocol error (optional feature only).

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - FIFO pointers and ostd_cnt go to 0; state goes to IDLE; err goes to 0.
  - Because outputs are derived from state and the empty flag, mst_rvalid=0, slv_rready=0 and slv_arvalid=0 in the cycle after the reset edge.
  - Reset mid-burst discards all in-flight routing.
- AR gating, combinational, no added latency:
  - full = (ostd_cnt==OSTDG_DEPTH).
  - slv_arvalid = mst_arvalid & ~full.
  - mst_arready = slv_arready & ~full.
- Push:
  - On slv_arvalid & slv_arready, the encoded index of grant (log2 of the one-hot vector) is written to the order FIFO.
  - A zero grant pushes index 0.
- State machine, 2 states:
  - IDLE: FIFO empty. slv_rready=0, mst_rvalid=0. Go to ROUTE on the next edge after the count becomes non-zero.
  - ROUTE: head index h selects the route.
    - mst_rvalid[h]=slv_rvalid; all other mst_rvalid bits are 0.
    - slv_rready=mst_rready[h].
    - mst_r* payload is the slave payload unchanged.
    - Pop on slv_rvalid & slv_rready & slv_rlast.
    - After a pop, return to IDLE if the count becomes 0; otherwise stay in ROUTE with the new head.
- Latency:
  - No AR→R bypass; the first beat is routable no earlier than 1 cycle after the push.
  - R path is combinational, with zero added latency.
- Simultaneous push and pop: ostd_cnt is unchanged and pointers advance independently.
- Full: no push is possible (AR is gated), so pushing and popping can never both run on a full FIFO.
- Wrap-around: pointers are $clog2(OSTDG_DEPTH) bits wide and wrap naturally; full/empty are taken from ostd_cnt.
- Non-RLAST beats do not pop; a burst of any length stays routed to one master.
- slv_rvalid in IDLE is ignored: slv_rready=0 and the beat is stalled, never dropped.

Optional Feature:
- Macro: AXICB_RESP_CHECK_EN.
- Defined: err is set and held until reset when any of these occurs:
  - slv_rvalid=1 while in IDLE (orphan response);
  - grant is not one-hot in a push cycle;
  - slv_rid changes between beats of one burst while slv_rvalid=1 and the burst is not yet popped.
  - Simulation adds an assertion on each condition.
- Undefined: err is tied to 0 and no check logic is built.

Decomposition:
- Package axicb_resp_pkg:
  - RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - state enum {IDLE, ROUTE};
  - one-hot-to-index function.
- Sub-module axicb_resp_fifo: a synchronous FIFO of index width × OSTDG_DEPTH entries, with push, pop, full, empty and count.

Test Plan:
- Single read: grant=0010, AR accepted, 4-beat R burst with mst_rready[1]=1 → mst_rvalid=0010 for 4 beats, pop on beat 4, ostd_cnt goes 0→1→0, state returns to IDLE.
- Ordering: ARs from m2 then m0 then m3 → bursts are routed to 0100, then 0001, then 1000 in that order, regardless of slv_rid.
- Full/backpressure: OSTDG_DEPTH=4 and 4 ARs pending → ostd_cnt=4 and mst_arready=0 while slv_arready=1; after one RLAST pop, the 5th AR is accepted on the next cycle.
- Simultaneous push/pop: an AR handshake in the same cycle as an RLAST handshake with ostd_cnt=2 → ostd_cnt stays 2, and the next burst routes to the correct new head.
- Stall and orphan: mst_rready[h]=0 for 3 cycles mid-burst → slv_rready=0 and data is held. Separately, slv_rvalid=1 while empty → slv_rready=0, mst_rvalid=0, and err=1 only with AXICB_RESP_CHECK_EN defined.
- Reset mid-burst: aresetn=0 after beat 2 of 4 → the cycle after the edge shows ostd_cnt=0, state IDLE, mst_rvalid=0; the next AR routes normally.

Source files
------------

// File: rtl/axicb_resp_pkg.sv
// Shared types and helpers for the crossbar read-response router.
package axicb_resp_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {IDLE, ROUTE} state_t;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axicb_resp_fifo.sv
// Order FIFO holding the winning master index of each accepted AR.
module axicb_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];
    assign count   = count_q;

    always_ff @(posedge aclk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axicb_resp_router.sv
// Steers one slave's R bursts back to the master that won each AR, in issue order.
// Optional protocol checking (sticky err) is built when AXICB_RESP_CHECK_EN is defined.
//
// state | meaning
// IDLE  | no routing active, R channel stalled
// ROUTE | head of order FIFO owns the R channel until RLAST handshake
module axicb_resp_router
    import axicb_resp_pkg::*;
#(
    parameter int MST_NB      = 4,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 8,
    parameter int OSTDG_DEPTH = 4
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [MST_NB-1:0]              grant,
    input  logic                           mst_arvalid,
    output logic                           mst_arready,
    output logic                           slv_arvalid,
    input  logic                           slv_arready,
    input  logic                           slv_rvalid,
    output logic                           slv_rready,
    input  logic [DATA_W-1:0]              slv_rdata,
    input  logic [1:0]                     slv_rresp,
    input  logic [ID_W-1:0]                slv_rid,
    input  logic                           slv_rlast,
    output logic [MST_NB-1:0]              mst_rvalid,
    input  logic [MST_NB-1:0]              mst_rready,
    output logic [DATA_W-1:0]              mst_rdata,
    output logic [1:0]                     mst_rresp,
    output logic [ID_W-1:0]                mst_rid,
    output logic                           mst_rlast,
    output logic [$clog2(OSTDG_DEPTH):0]   ostd_cnt,
    output logic                           err
);
    localparam int IW = $clog2(MST_NB);

    state_t        state;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          route;
    logic [3:0]    grant_ext;
    logic [1:0]    grant_idx;
    logic [IW-1:0] head;

    assign slv_arvalid = mst_arvalid & ~full;
    assign mst_arready = slv_arready & ~full;
    assign push        = slv_arvalid & slv_arready;

    always_comb begin
        grant_ext             = '0;
        grant_ext[MST_NB-1:0] = grant;
    end
    assign grant_idx = onehot_to_idx(grant_ext);

    axicb_resp_fifo #(.DEPTH(OSTDG_DEPTH), .W(IW)) u_order_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .din     (grant_idx[IW-1:0]),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (ostd_cnt)
    );

    assign route = (state == ROUTE) & ~empty;

    always_comb begin
        mst_rvalid = '0;
        slv_rready = 1'b0;
        if (route) begin
            mst_rvalid[head] = slv_rvalid;
            slv_rready       = mst_rready[head];
        end
    end

    assign pop       = route & slv_rvalid & slv_rready & slv_rlast;
    assign mst_rdata = slv_rdata;
    assign mst_rresp = slv_rresp;
    assign mst_rid   = slv_rid;
    assign mst_rlast = slv_rlast;

    // A concurrent push keeps the count non-zero, so only a lone pop of the last entry idles.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty) state <= ROUTE;
                ROUTE:   if (pop && !push && ostd_cnt == 1) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXICB_RESP_CHECK_EN
    logic            orphan;
    logic            bad_grant;
    logic            rid_flip;
    logic            seen;
    logic [ID_W-1:0] rid_q;

    assign orphan    = (state == IDLE) & slv_rvalid;
    assign bad_grant = push & ~((grant != '0) && ((grant & (grant - 1'b1)) == '0));
    assign rid_flip  = route & slv_rvalid & seen & (slv_rid != rid_q);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err   <= 1'b0;
            seen  <= 1'b0;
            rid_q <= '0;
        end else begin
            if (orphan | bad_grant | rid_flip) err <= 1'b1;
            if (pop) begin
                seen <= 1'b0;
            end else if (route & slv_rvalid) begin
                seen  <= 1'b1;
                rid_q <= slv_rid;
            end
        end
    end

`ifndef SYNTHESIS
    a_orphan:    assert property (@(posedge aclk) disable iff (!aresetn) !orphan)
        else $error("orphan R response while idle");
    a_bad_grant: assert property (@(posedge aclk) disable iff (!aresetn) !bad_grant)
        else $error("grant not one-hot on AR push");
    a_rid_flip:  assert property (@(posedge aclk) disable iff (!aresetn) !rid_flip)
        else $error("RID changed inside a burst");
`endif
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_resp_router.sv
// Self-checking bench for axicb_resp_router: directed table, corner sequences, random vs queue model.
module tb_axicb_resp_router;
    import axicb_resp_pkg::*;

    localparam int MST_NB = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int DEPTH  = 4;

    logic              aclk;
    logic              aresetn;
    logic [MST_NB-1:0] grant;
    logic              mst_arvalid;
    logic              mst_arready;
    logic              slv_arvalid;
    logic              slv_arready;
    logic              slv_rvalid;
    logic              slv_rready;
    logic [DATA_W-1:0] slv_rdata;
    logic [1:0]        slv_rresp;
    logic [ID_W-1:0]   slv_rid;
    logic              slv_rlast;
    logic [MST_NB-1:0] mst_rvalid;
    logic [MST_NB-1:0] mst_rready;
    logic [DATA_W-1:0] mst_rdata;
    logic [1:0]        mst_rresp;
    logic [ID_W-1:0]   mst_rid;
    logic              mst_rlast;
    logic [2:0]        ostd_cnt;
    logic              err;

    axicb_resp_router #(.MST_NB(MST_NB), .DATA_W(DATA_W), .ID_W(ID_W), .OSTDG_DEPTH(DEPTH)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .grant       (grant),
        .mst_arvalid (mst_arvalid),
        .mst_arready (mst_arready),
        .slv_arvalid (slv_arvalid),
        .slv_arready (slv_arready),
        .slv_rvalid  (slv_rvalid),
        .slv_rready  (slv_rready),
        .slv_rdata   (slv_rdata),
        .slv_rresp   (slv_rresp),
        .slv_rid     (slv_rid),
        .slv_rlast   (slv_rlast),
        .mst_rvalid  (mst_rvalid),
        .mst_rready  (mst_rready),
        .mst_rdata   (mst_rdata),
        .mst_rresp   (mst_rresp),
        .mst_rid     (mst_rid),
        .mst_rlast   (mst_rlast),
        .ostd_cnt    (ostd_cnt),
        .err         (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total_cnt  = 0;
    int passed_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        else passed_cnt++;
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge for sampling.
    task automatic drive(input logic [3:0] g, input logic arv, input logic sarr, input logic rv,
                         input logic rl, input logic [3:0] rr, input logic [7:0] id,
                         input logic [31:0] data);
        grant       = g;
        mst_arvalid = arv;
        slv_arready = sarr;
        slv_rvalid  = rv;
        slv_rlast   = rl;
        mst_rready  = rr;
        slv_rid     = id;
        slv_rdata   = data;
        slv_rresp   = SLVERR;
        @(negedge aclk);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic [3:0] g;
        logic       arv;
        logic       sarr;
        logic       rv;
        logic       rl;
        logic [3:0] rr;
        logic [3:0] e_mrv;
        logic       e_srr;
        logic       e_mar;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    int         q[$];
    bit         active;
    logic [3:0] rg;
    logic       rarv, rsarr, rrv, rrl;
    logic [3:0] rrr;
    logic [7:0] rid_cur;
    logic [31:0] rdat;
    logic [3:0] e_mrv;
    logic       e_srr, e_mar, e_sav, do_push, do_pop;
    int         size_before;

    initial begin
        // single 4-beat read to master 1 with a 3-cycle stall after beat 2
        tbl[0] = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 3'd0};
        tbl[1] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 3'd1};
        tbl[2] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd1};
        tbl[3] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd1};
        tbl[4] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0010, 1'b0, 1'b0, 3'd1};
        tbl[5] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0010, 1'b0, 1'b0, 3'd1};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0010, 1'b0, 1'b0, 3'd1};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd1};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd1};
        tbl[9] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 3'd0};

        aresetn = 1'b0;
        grant = '0; mst_arvalid = 1'b0; slv_arready = 1'b0; slv_rvalid = 1'b0;
        slv_rlast = 1'b0; mst_rready = '0; slv_rid = '0; slv_rdata = '0; slv_rresp = OKAY;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // reset state
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
        check("rst_cnt",    32'(ostd_cnt), 32'd0);
        check("rst_mrv",    32'(mst_rvalid), 32'd0);
        check("rst_srr",    32'(slv_rready), 32'd0);
        check("rst_sav",    32'(slv_arvalid), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].g, tbl[i].arv, tbl[i].sarr, tbl[i].rv, tbl[i].rl, tbl[i].rr, 8'h42,
                  32'hA000_0000 + 32'(i));
            check($sformatf("tbl%0d_mrv", i), 32'(mst_rvalid), 32'(tbl[i].e_mrv));
            check($sformatf("tbl%0d_srr", i), 32'(slv_rready), 32'(tbl[i].e_srr));
            check($sformatf("tbl%0d_mar", i), 32'(mst_arready), 32'(tbl[i].e_mar));
            check($sformatf("tbl%0d_cnt", i), 32'(ostd_cnt), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_dat", i), mst_rdata, 32'hA000_0000 + 32'(i));
            step();
        end

        // fill to depth: m2, m0, m3, m1
        drive(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("fill0_mar", 32'(mst_arready), 32'd1); step();
        drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("fill1_mar", 32'(mst_arready), 32'd1); step();
        drive(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("fill2_mar", 32'(mst_arready), 32'd1); step();
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("fill3_mar", 32'(mst_arready), 32'd1); step();
        // 5th AR blocked while full; pop of the m2 burst in the same cycle
        drive(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 8'h09, 32'h11);
        check("full_cnt", 32'(ostd_cnt), 32'd4);
        check("full_mar", 32'(mst_arready), 32'd0);
        check("full_sav", 32'(slv_arvalid), 32'd0);
        check("ord0_mrv", 32'(mst_rvalid), 32'b0100);
        step();
        drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
        check("refill_mar", 32'(mst_arready), 32'd1);
        check("refill_cnt", 32'(ostd_cnt), 32'd3);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 8'h01, 32'h0); check("ord1_mrv", 32'(mst_rvalid), 32'b0001); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 8'h77, 32'h0); check("ord2_mrv", 32'(mst_rvalid), 32'b1000); step();
        // simultaneous push and pop at count 2
        drive(4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 8'h05, 32'h0);
        check("sim_cnt_pre", 32'(ostd_cnt), 32'd2);
        check("sim_mrv", 32'(mst_rvalid), 32'b0010);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("sim_cnt_post", 32'(ostd_cnt), 32'd2); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 8'h06, 32'h0); check("sim_head1", 32'(mst_rvalid), 32'b0001); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 8'h07, 32'h0); check("sim_head2", 32'(mst_rvalid), 32'b0100); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); check("drain_cnt", 32'(ostd_cnt), 32'd0); step();

        // reset after beat 2 of a 4-beat burst
        drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h2A, 32'h1); check("mid_b1", 32'(mst_rvalid), 32'b0001); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h2A, 32'h2); check("mid_b2", 32'(mst_rvalid), 32'b0001); step();
        aresetn = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); step();
        aresetn = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
        check("mrst_cnt", 32'(ostd_cnt), 32'd0);
        check("mrst_srr", 32'(slv_rready), 32'd0);
        check("mrst_mrv", 32'(mst_rvalid), 32'd0);
        step();
        drive(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 8'h3C, 32'h5);
        check("post_rst_mrv", 32'(mst_rvalid), 32'b1000);
        check("post_rst_srr", 32'(slv_rready), 32'd1);
        step();

        // orphan response while empty
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
        check("orph_srr", 32'(slv_rready), 32'd0);
        check("orph_mrv", 32'(mst_rvalid), 32'd0);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
`ifdef AXICB_RESP_CHECK_EN
        check("orph_err", 32'(err), 32'd1);
`else
        check("orph_err", 32'(err), 32'd0);
`endif
        step();

        // randomized traffic against an order-queue model
        aresetn = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        step();
        aresetn = 1'b1;
        q.delete();
        active  = 1'b0;
        rid_cur = 8'h10;
        for (int c = 0; c < 400; c++) begin
            rg    = 4'(1 << $urandom_range(0, 3));
            rarv  = 1'($urandom_range(0, 1));
            rsarr = 1'($urandom_range(0, 1));
            rrv   = active ? ($urandom_range(0, 3) != 0) : 1'b0;
            rrl   = ($urandom_range(0, 2) == 0);
            rrr   = 4'($urandom_range(0, 15));
            rdat  = $urandom;
            drive(rg, rarv, rsarr, rrv, rrl, rrr, rid_cur, rdat);

            e_sav = rarv && (q.size() < DEPTH);
            e_mar = rsarr && (q.size() < DEPTH);
            e_mrv = (active && rrv) ? 4'(1 << q[0]) : 4'b0000;
            e_srr = active ? rrr[q[0]] : 1'b0;
            check("rnd_sav", 32'(slv_arvalid), 32'(e_sav));
            check("rnd_mar", 32'(mst_arready), 32'(e_mar));
            check("rnd_mrv", 32'(mst_rvalid), 32'(e_mrv));
            check("rnd_srr", 32'(slv_rready), 32'(e_srr));
            check("rnd_cnt", 32'(ostd_cnt), 32'(q.size()));
            check("rnd_dat", mst_rdata, rdat);

            do_push     = e_sav && rsarr;
            do_pop      = active && rrv && e_srr && rrl;
            size_before = q.size();
            if (do_pop) begin
                void'(q.pop_front());
                rid_cur = rid_cur + 8'd1;
            end
            if (do_push) begin
                for (int k = 0; k < 4; k++) if (rg[k]) q.push_back(k);
            end
            active = active ? (q.size() != 0) : (size_before != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
